trace_event_arbiter: RTL and testbench
======================================

# trace_event_arbiter

Round-robin, packet-locking arbiter that merges the per-core trace/stdout event streams of a compute tile (one stream per core, `NUM_CORES` requesters) onto a single valid/ready stream feeding the debug/trace monitor path. Multi-flit events stay contiguous. Output is registered (one pipeline stage). The arbiter tags each flit with its source core index and keeps a completed-packet counter for the simulation monitors.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesting cores (≥2).
- `DATA_WIDTH`, 32: flit payload width.
- `ID_WIDTH`, 2: source-index width (≥ clog2(NUM_REQ)).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  NUM_REQ  per-requester flit valid.
- `in_ready`  out  NUM_REQ  per-requester flit accept.
- `in_data`  in  NUM_REQ*DATA_WIDTH  flits; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `in_last`  in  NUM_REQ  flit is last of packet.
- `out_valid`  out  1  registered output flit valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  DATA_WIDTH  output flit.
- `out_last`  out  1  output last flag.
- `out_src`  out  ID_WIDTH  requester index of the output flit.
- `pkt_count`  out  32  completed packets (last flits accepted at output), wraps.

## Operation
- Input transfer on `in_valid[i] && in_ready[i]`. Output transfer on `out_valid && out_ready`.
- Output register can load when `!out_valid || out_ready` (`can_load`).
- State machine:
  - IDLE: the grant goes to the first requester with `in_valid` set, searching `ptr+1, ptr+2, …` modulo NUM_REQ. `in_ready[grant] = can_load`, and all other `in_ready` bits are 0. On transfer: if `in_last`, `ptr <= grant` and the FSM stays IDLE. Otherwise `owner <= grant`, the FSM goes to LOCKED, and `ptr` is unchanged.
  - LOCKED: only `owner` may transfer. `in_ready[owner] = can_load`. When the owner deasserts valid, the lock is held and other requesters wait. On a transfer with `in_last`: `ptr <= owner`, FSM goes to IDLE.
- At most one `in_ready` bit is high in any cycle. `in_ready` never depends on another requester's `in_data`.
- Output register:
  - On input transfer, load `{data, last, src}` and set `out_valid`.
  - Else on output transfer, clear `out_valid`.
- `pkt_count` increments by 1 on every output transfer with `out_last`. It wraps from 0xFFFFFFFF to 0.
- When no requester is valid in IDLE, there is no grant, all `in_ready` are 0, and `ptr` is unchanged.

## Timing
- Reset (`rst_n` low at a clock edge) forces:
  - `out_valid`=0, `out_data`=0, `out_last`=0, `out_src`=0, `pkt_count`=0.
  - FSM=IDLE, `ptr`=NUM_REQ-1, so requester 0 has first priority.
  - `in_ready` is all 0 while reset is asserted.
- Reset mid-packet drops the lock and any held output flit. No partial packet is resumed.
- Latency: an input flit accepted in cycle n appears on `out_*` in cycle n+1.
- Throughput: 1 flit/cycle sustained while `out_ready`=1 (load and drain happen in the same cycle).
- `out_ready`=0 with `out_valid`=1: all `out_*` outputs are held stable and all `in_ready`=0.
- `in_ready` is combinational from `in_valid`, FSM, `ptr`, `out_valid`, `out_ready`. There is no combinational path from `in_data` or `in_last`.
- A packet switch costs no idle cycle: the last flit of A in cycle n and the first flit of B in cycle n+1 are allowed.

## Test plan
- Single-flit round robin: all 4 requesters continuously valid with `in_last`=1, `out_ready`=1 → `out_src` sequence 0,1,2,3,0,1… from the cycle after reset release, and `pkt_count`=8 after 8 flits.
- Packet lock: req1 sends a 3-flit packet (0xA1, 0xA2, 0xA3 last) while req0 and req2 are valid → output 0xA1, 0xA2, 0xA3 with `out_src`=1 contiguous, then req2 (rotation from ptr=1), then req0.
- Lock with bubble: req3 sends its first flit, deasserts valid for 3 cycles, then sends its last flit while req0 is valid throughout → req0 sees `in_ready`=0 for the whole gap, and req0's flit follows req3's last flit.
- Backpressure: `out_ready` held 0 for 5 cycles with `out_valid`=1 and `out_data`=0x55 → `out_*` stable and all `in_ready`=0. On release, 0x55 drains and the next flit loads in the same cycle.
- Reset mid-packet: `rst_n`=0 for one edge while req2 is LOCKED → next cycle `out_valid`=0, `pkt_count`=0, FSM IDLE. With req0 and req2 both valid afterward, req0 is granted first.
- Counter wrap: force `pkt_count` to 0xFFFFFFFE, then 2 single-flit packets are accepted at the output → `pkt_count`=0.

Source files
------------

// File: rtl/trace_event_arbiter.sv
// rtl/trace_event_arbiter.sv - round-robin packet-locking arbiter for per-core trace event streams
// Registered single-stage output tagged with source index, plus a completed-packet counter.
module trace_event_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            in_valid,
  output logic [NUM_REQ-1:0]            in_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]            in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  output logic [ID_WIDTH-1:0]           out_src,
  output logic [31:0]                   pkt_count
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [ID_WIDTH-1:0] owner_q, owner_d;
  logic [ID_WIDTH-1:0] grant, cand, sel;
  logic                grant_valid;
  logic                can_load, xfer, out_xfer;
  logic [31:0]         pkt_count_q;

  assign can_load = !out_valid || out_ready;
  assign out_xfer = out_valid && out_ready;

  // Scan from farthest to nearest so the requester closest after ptr is assigned last and wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_WIDTH'((int'(ptr_q) + k) % NUM_REQ);
      if (in_valid[cand]) begin
        grant       = cand;
        grant_valid = 1'b1;
      end
    end
  end

  assign sel = (state_q == LOCKED) ? owner_q : grant;

  always_comb begin
    in_ready = '0;
    if (rst_n && can_load) begin
      if (state_q == LOCKED) begin
        in_ready[owner_q] = 1'b1;
      end else if (grant_valid) begin
        in_ready[grant] = 1'b1;
      end
    end
  end

  assign xfer = |(in_valid & in_ready);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (xfer) begin
      if (in_last[sel]) begin
        ptr_d   = sel;
        state_d = IDLE;
      end else if (state_q == IDLE) begin
        owner_d = sel;
        state_d = LOCKED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= ID_WIDTH'(NUM_REQ - 1);
      owner_q     <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      out_src     <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
        out_last  <= in_last[sel];
        out_src   <= sel;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
      if (out_xfer && out_last) begin
        pkt_count_q <= pkt_count_q + 32'd1;
      end
    end
  end

  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_trace_event_arbiter.sv
// tb/tb_trace_event_arbiter.sv - directed self-checking bench for trace_event_arbiter
module tb_trace_event_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    in_ready;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]    in_last = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [IW-1:0]   out_src;
  logic [31:0]     pkt_count;

  int n_checks = 0;
  int n_fail = 0;

  bit          m_locked = 1'b0;
  int          m_owner = 0;
  int          m_ptr = N - 1;
  bit          m_ov = 1'b0;
  logic [31:0] m_data = '0;
  bit          m_last = 1'b0;
  int          m_src = 0;
  logic [31:0] m_count = '0;
  int          preset_seq = 0;
  int          preset_seen = 0;
  logic [31:0] preset_val = '0;

  always #5 clk = ~clk;

  trace_event_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_src(out_src), .pkt_count(pkt_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Who may push now: the lock owner, else the nearest valid requester after the last winner.
  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = '0;
    if (!rst_n || (m_ov && !out_ready)) return r;
    if (m_locked) return N'(1) << m_owner;
    for (int d = 1; d <= N; d++) begin
      if (in_valid[IW'((m_ptr + d) % N)]) return N'(1) << ((m_ptr + d) % N);
    end
    return r;
  endfunction

  always @(posedge clk) begin : model
    logic [N-1:0] acc;
    int g;
    if (preset_seq != preset_seen) begin
      m_count = preset_val;
      preset_seen = preset_seq;
    end
    if (!rst_n) begin
      m_locked = 1'b0; m_owner = 0; m_ptr = N - 1;
      m_ov = 1'b0; m_data = '0; m_last = 1'b0; m_src = 0; m_count = '0;
    end else begin
      acc = exp_ready() & in_valid;
      if (m_ov && out_ready && m_last) m_count = m_count + 32'd1;
      if (acc != '0) begin
        g = $clog2(acc);
        m_ov = 1'b1;
        m_data = in_data[g*DW +: DW];
        m_last = in_last[IW'(g)];
        m_src = g;
        if (m_last) begin
          m_locked = 1'b0;
          m_ptr = g;
        end else begin
          m_locked = 1'b1;
          m_owner = g;
        end
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    chk("model_in_ready", {28'd0, in_ready}, {28'd0, exp_ready()});
    chk("model_out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    chk("model_pkt_count", pkt_count, m_count);
    if (m_ov) begin
      chk("model_out_data", out_data, m_data);
      chk("model_out_last", {31'd0, out_last}, {31'd0, m_last});
      chk("model_out_src", {30'd0, out_src}, m_src);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setreq(input int i, input logic v, input logic [DW-1:0] d, input logic l);
    in_valid[IW'(i)] = v;
    in_data[i*DW +: DW] = d;
    in_last[IW'(i)] = l;
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_out_last", {31'd0, out_last}, 32'd0);
    chk("reset_out_src", {30'd0, out_src}, 32'd0);
    chk("reset_pkt_count", pkt_count, 32'd0);
    chk("reset_in_ready", {28'd0, in_ready}, 32'd0);

    for (int i = 0; i < N; i++) setreq(i, 1'b1, 32'h100 + i, 1'b1);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_src", {30'd0, out_src}, k % 4);
    end
    in_valid = '0;
    tick();
    chk("rr_pkt_count", pkt_count, 32'd8);
    chk("rr_drained", {31'd0, out_valid}, 32'd0);

    setreq(0, 1'b1, 32'h10, 1'b1);
    tick();
    setreq(0, 1'b1, 32'h20, 1'b1);
    setreq(1, 1'b1, 32'hA1, 1'b0);
    setreq(2, 1'b1, 32'hC2, 1'b1);
    tick();
    chk("lock_a1", out_data, 32'hA1);
    chk("lock_a1_src", {30'd0, out_src}, 32'd1);
    setreq(1, 1'b1, 32'hA2, 1'b0);
    tick();
    chk("lock_a2", out_data, 32'hA2);
    setreq(1, 1'b1, 32'hA3, 1'b1);
    tick();
    chk("lock_a3", out_data, 32'hA3);
    chk("lock_a3_last", {31'd0, out_last}, 32'd1);
    setreq(1, 1'b0, 32'h0, 1'b0);
    tick();
    chk("lock_next_src", {30'd0, out_src}, 32'd2);
    setreq(2, 1'b0, 32'h0, 1'b0);
    tick();
    chk("lock_then_src", {30'd0, out_src}, 32'd0);
    chk("lock_then_data", out_data, 32'h20);
    setreq(0, 1'b0, 32'h0, 1'b0);

    setreq(3, 1'b1, 32'hB1, 1'b0);
    setreq(0, 1'b1, 32'h30, 1'b1);
    tick();
    chk("bubble_first_src", {30'd0, out_src}, 32'd3);
    setreq(3, 1'b0, 32'h0, 1'b0);
    repeat (3) begin
      #1;
      chk("bubble_req0_ready", {31'd0, in_ready[0]}, 32'd0);
      tick();
    end
    setreq(3, 1'b1, 32'hB2, 1'b1);
    tick();
    chk("bubble_last", out_data, 32'hB2);
    setreq(3, 1'b0, 32'h0, 1'b0);
    tick();
    chk("bubble_after_src", {30'd0, out_src}, 32'd0);
    chk("bubble_after_data", out_data, 32'h30);
    setreq(0, 1'b0, 32'h0, 1'b0);

    setreq(0, 1'b1, 32'h55, 1'b1);
    tick();
    setreq(0, 1'b0, 32'h0, 1'b0);
    setreq(1, 1'b1, 32'h66, 1'b1);
    out_ready = 1'b0;
    repeat (5) begin
      #1;
      chk("bp_in_ready", {28'd0, in_ready}, 32'd0);
      chk("bp_out_data", out_data, 32'h55);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_next_data", out_data, 32'h66);
    chk("bp_count", pkt_count, 32'd15);
    setreq(1, 1'b0, 32'h0, 1'b0);

    setreq(2, 1'b1, 32'hD1, 1'b0);
    tick();
    rst_n = 1'b0;
    setreq(0, 1'b1, 32'h40, 1'b1);
    setreq(2, 1'b1, 32'hD2, 1'b1);
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pkt_count", pkt_count, 32'd0);
    chk("rst_in_ready", {28'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_grant_req0", {28'd0, in_ready}, 32'd1);
    tick();
    chk("rst_first_src", {30'd0, out_src}, 32'd0);
    setreq(0, 1'b0, 32'h0, 1'b0);
    tick();
    chk("rst_second_data", out_data, 32'hD2);
    setreq(2, 1'b0, 32'h0, 1'b0);
    tick();

    @(negedge clk);
    #1;
    force dut.pkt_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.pkt_count_q;
    preset_val = 32'hFFFF_FFFE;
    preset_seq++;
    setreq(0, 1'b1, 32'h70, 1'b1);
    tick();
    setreq(0, 1'b0, 32'h0, 1'b0);
    setreq(1, 1'b1, 32'h71, 1'b1);
    tick();
    chk("wrap_before", pkt_count, 32'hFFFF_FFFF);
    setreq(1, 1'b0, 32'h0, 1'b0);
    tick();
    chk("wrap_after", pkt_count, 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
